// File: rtl/omsp_spm_cmd_seq.sv
// SPM command sequencer: turns protect/unprotect/query commands
// into SPM control strobes and a single buffered response.
module omsp_spm_cmd_seq #(
  parameter logic [2:0] QRY_FIRST_CODE = 3'd1
) (
  input  logic        mclk,
  input  logic        puc_rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_arg0,
  input  logic [15:0] cmd_arg1,
  input  logic [15:0] cmd_arg2,
  input  logic [15:0] cmd_arg3,
  input  logic [15:0] cmd_sel,
  output logic        update_spm,
  output logic        enable_spm,
  output logic [15:0] r12,
  output logic [15:0] r13,
  output logic [15:0] r14,
  output logic [15:0] r15,
  output logic [15:0] spm_select,
  output logic [2:0]  data_request,
  input  logic        violation,
  input  logic        spm_select_valid,
  input  logic [15:0] requested_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [1:0]  rsp_status,
  output logic [15:0] rsp_data0,
  output logic [15:0] rsp_data1,
  output logic [15:0] rsp_data2,
  output logic [15:0] rsp_data3
);

  typedef enum logic [2:0] {
    IDLE, ISSUE, QSEL, QREAD, RESP
  } state_t;

  localparam logic [1:0] OP_PROT = 2'b00;
  localparam logic [1:0] OP_QRY  = 2'b10;
  localparam logic [1:0] OP_BAD  = 2'b11;

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_VIOL  = 2'b01;
  localparam logic [1:0] ST_NOSPM = 2'b10;
  localparam logic [1:0] ST_BADOP = 2'b11;

  state_t      state, state_nxt;
  logic [1:0]  k;
  logic [1:0]  op_q;
  logic [15:0] arg0_q, arg1_q, arg2_q, arg3_q;
  logic [15:0] sel_q;
  logic [1:0]  status_q;
  logic [15:0] data_q [4];

  assign rsp_status = status_q;
  assign rsp_data0  = data_q[0];
  assign rsp_data1  = data_q[1];
  assign rsp_data2  = data_q[2];
  assign rsp_data3  = data_q[3];

  // State register
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state decode and state-driven outputs
  always_comb begin
    state_nxt    = state;
    cmd_ready    = 1'b0;
    update_spm   = 1'b0;
    enable_spm   = 1'b0;
    r12          = '0;
    r13          = '0;
    r14          = '0;
    r15          = '0;
    spm_select   = '0;
    data_request = '0;
    rsp_valid    = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready = ~puc_rst;
        if (cmd_valid) begin
          unique case (cmd_op)
            OP_QRY:  state_nxt = QSEL;
            OP_BAD:  state_nxt = RESP;
            default: state_nxt = ISSUE;
          endcase
        end
      end
      ISSUE: begin
        update_spm = 1'b1;
        enable_spm = (op_q == OP_PROT);
        r12        = arg0_q;
        r13        = arg1_q;
        r14        = arg2_q;
        r15        = arg3_q;
        state_nxt  = RESP;
      end
      QSEL: begin
        spm_select = sel_q;
        state_nxt  = spm_select_valid ? QREAD : RESP;
      end
      QREAD: begin
        spm_select   = sel_q;
        data_request = QRY_FIRST_CODE + {1'b0, k};
        if (k == 2'd3) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Command capture, beat counter and response buffer
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      k        <= '0;
      op_q     <= '0;
      arg0_q   <= '0;
      arg1_q   <= '0;
      arg2_q   <= '0;
      arg3_q   <= '0;
      sel_q    <= '0;
      status_q <= '0;
      for (int i = 0; i < 4; i++) data_q[i] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_q   <= cmd_op;
            arg0_q <= cmd_arg0;
            arg1_q <= cmd_arg1;
            arg2_q <= cmd_arg2;
            arg3_q <= cmd_arg3;
            sel_q  <= cmd_sel;
            if (cmd_op == OP_BAD) begin
              status_q <= ST_BADOP;
              for (int i = 0; i < 4; i++) data_q[i] <= '0;
            end
          end
        end
        ISSUE: begin
          if (op_q == OP_PROT && violation) status_q <= ST_VIOL;
          else                              status_q <= ST_OK;
        end
        QSEL: begin
          k <= '0;
          if (!spm_select_valid) begin
            status_q <= ST_NOSPM;
            for (int i = 0; i < 4; i++) data_q[i] <= '0;
          end
        end
        QREAD: begin
          data_q[k] <= requested_data;
          k         <= k + 2'd1;
          if (k == 2'd3) status_q <= ST_OK;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_omsp_spm_cmd_seq.sv
// Bench for omsp_spm_cmd_seq: transaction-level model with per-cycle
// compare, plus directed commands with literal expectations.
module tb_omsp_spm_cmd_seq;

  localparam logic [2:0] QFC = 3'd1;

  logic        mclk = 1'b0;
  logic        puc_rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = '0;
  logic [15:0] cmd_arg0 = '0, cmd_arg1 = '0;
  logic [15:0] cmd_arg2 = '0, cmd_arg3 = '0;
  logic [15:0] cmd_sel = '0;
  logic        update_spm, enable_spm;
  logic [15:0] r12, r13, r14, r15;
  logic [15:0] spm_select;
  logic [2:0]  data_request;
  logic        violation = 1'b0;
  logic        spm_select_valid = 1'b0;
  logic [15:0] requested_data;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [1:0]  rsp_status;
  logic [15:0] rsp_data0, rsp_data1, rsp_data2, rsp_data3;
  logic [15:0] rd_base = 16'hA000;

  omsp_spm_cmd_seq #(.QRY_FIRST_CODE(QFC)) dut (
    .mclk(mclk), .puc_rst(puc_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .cmd_arg0(cmd_arg0), .cmd_arg1(cmd_arg1),
    .cmd_arg2(cmd_arg2), .cmd_arg3(cmd_arg3),
    .cmd_sel(cmd_sel),
    .update_spm(update_spm), .enable_spm(enable_spm),
    .r12(r12), .r13(r13), .r14(r14), .r15(r15),
    .spm_select(spm_select), .data_request(data_request),
    .violation(violation),
    .spm_select_valid(spm_select_valid),
    .requested_data(requested_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_status(rsp_status),
    .rsp_data0(rsp_data0), .rsp_data1(rsp_data1),
    .rsp_data2(rsp_data2), .rsp_data3(rsp_data3)
  );

  // SPM control stand-in: word = base + code
  assign requested_data = rd_base + 16'(data_request);

  always #5 mclk = ~mclk;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  // kind: 0 = update beat, 1 = select beat, 2 = read beat
  typedef struct packed {
    logic        upd;
    logic        en;
    logic [15:0] a0, a1, a2, a3;
    logic [15:0] sel;
    logic [2:0]  dreq;
    logic [1:0]  kind;
    logic [1:0]  idx;
  } beat_t;

  beat_t       mq[$];
  beat_t       mb, cb;
  bit          m_resp = 1'b0;
  logic [1:0]  m_st = '0;
  logic [15:0] m_d [4] = '{default: '0};

  always @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      mq.delete();
      m_resp = 1'b0;
      m_st   = '0;
      for (int i = 0; i < 4; i++) m_d[i] = '0;
    end else if (m_resp) begin
      if (rsp_ready) m_resp = 1'b0;
    end else if (mq.size() != 0) begin
      mb = mq.pop_front();
      if (mb.kind == 2'd0) begin
        m_st   = (mb.en && violation) ? 2'd1 : 2'd0;
        m_resp = 1'b1;
      end else if (mb.kind == 2'd1) begin
        if (!spm_select_valid) begin
          m_st = 2'd2;
          for (int i = 0; i < 4; i++) m_d[i] = '0;
          m_resp = 1'b1;
        end else begin
          for (int i = 0; i < 4; i++) begin
            beat_t b;
            b      = '0;
            b.sel  = mb.sel;
            b.kind = 2'd2;
            b.idx  = 2'(i);
            b.dreq = QFC + 3'(i);
            mq.push_back(b);
          end
        end
      end else begin
        m_d[mb.idx] = rd_base + 16'(mb.dreq);
        if (mb.idx == 2'd3) begin
          m_st   = 2'd0;
          m_resp = 1'b1;
        end
      end
    end else if (cmd_valid) begin
      mb = '0;
      if (cmd_op == 2'b11) begin
        m_st = 2'd3;
        for (int i = 0; i < 4; i++) m_d[i] = '0;
        m_resp = 1'b1;
      end else if (cmd_op == 2'b10) begin
        mb.sel  = cmd_sel;
        mb.kind = 2'd1;
        mq.push_back(mb);
      end else begin
        mb.upd  = 1'b1;
        mb.en   = (cmd_op == 2'b00);
        mb.a0   = cmd_arg0;
        mb.a1   = cmd_arg1;
        mb.a2   = cmd_arg2;
        mb.a3   = cmd_arg3;
        mb.kind = 2'd0;
        mq.push_back(mb);
      end
    end
  end

  int          upd_cnt = 0;
  int          dreq_cnt = 0;
  logic [15:0] last_r12 = '0, last_r15 = '0;
  logic        last_en = 1'b0;

  // Per-cycle compare against the model, away from the clock edge
  always @(negedge mclk) begin
    cb = (mq.size() != 0) ? mq[0] : '0;
    chk("cmd_ready", 32'(cmd_ready),
        32'(!puc_rst && !m_resp && mq.size() == 0));
    chk("update_spm", 32'(update_spm), 32'(cb.upd));
    chk("enable_spm", 32'(enable_spm), 32'(cb.en));
    chk("r12", 32'(r12), 32'(cb.a0));
    chk("r13", 32'(r13), 32'(cb.a1));
    chk("r14", 32'(r14), 32'(cb.a2));
    chk("r15", 32'(r15), 32'(cb.a3));
    chk("spm_select", 32'(spm_select), 32'(cb.sel));
    chk("data_request", 32'(data_request), 32'(cb.dreq));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_resp));
    chk("rsp_status", 32'(rsp_status), 32'(m_st));
    chk("rsp_data0", 32'(rsp_data0), 32'(m_d[0]));
    chk("rsp_data1", 32'(rsp_data1), 32'(m_d[1]));
    chk("rsp_data2", 32'(rsp_data2), 32'(m_d[2]));
    chk("rsp_data3", 32'(rsp_data3), 32'(m_d[3]));
    if (update_spm) begin
      upd_cnt++;
      last_r12 = r12;
      last_r15 = r15;
      last_en  = enable_spm;
    end
    if (data_request != 3'd0) dreq_cnt++;
  end

  // ---------------- directed stimulus ----------------
  task automatic run(input logic [1:0]  op,
                     input logic [15:0] a0, a1, a2, a3, sel,
                     input int exp_lat,
                     input int hold,
                     input int linger,
                     input logic [1:0] exp_st);
    int n;
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge mclk); #1;
    end
    chk("ready_wait", 32'(ok), 32'd1);
    cmd_op = op;
    cmd_arg0 = a0; cmd_arg1 = a1;
    cmd_arg2 = a2; cmd_arg3 = a3;
    cmd_sel = sel;
    cmd_valid = 1'b1;
    @(posedge mclk); #1;
    if (linger == 0) cmd_valid = 1'b0;
    else fork
      begin
        repeat (linger) @(posedge mclk);
        #1 cmd_valid = 1'b0;
      end
    join_none
    n = 1;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
      @(posedge mclk); #1;
      n++;
    end
    if (!ok) begin
      chk("rsp_timeout", 32'd0, 32'd1);
      return;
    end
    chk("latency", 32'(n), 32'(exp_lat));
    chk("status", 32'(rsp_status), 32'(exp_st));
    repeat (hold) begin
      @(posedge mclk); #1;
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_status", 32'(rsp_status), 32'(exp_st));
    end
    rsp_ready = 1'b1;
    @(posedge mclk); #1;
    rsp_ready = 1'b0;
    chk("post_valid", 32'(rsp_valid), 32'd0);
    chk("post_ready", 32'(cmd_ready), 32'd1);
  endtask

  int u0, d0;

  initial begin
    repeat (3) @(posedge mclk);
    #1;
    chk("rst_ready", 32'(cmd_ready), 32'd0);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_upd", 32'(update_spm), 32'd0);
    #2 puc_rst = 1'b0;
    #1 chk("rel_ready", 32'(cmd_ready), 32'd1);
    @(posedge mclk); #1;

    // Protect, no violation
    u0 = upd_cnt;
    run(2'b00, 16'h8000, 16'h8100, 16'h9000, 16'h9100,
        16'h0, 2, 0, 0, 2'd0);
    chk("prot_upd_once", 32'(upd_cnt - u0), 32'd1);
    chk("prot_r12", 32'(last_r12), 32'h8000);
    chk("prot_r15", 32'(last_r15), 32'h9100);
    chk("prot_en", 32'(last_en), 32'd1);

    // Protect with violation
    violation = 1'b1;
    u0 = upd_cnt;
    run(2'b00, 16'h1000, 16'h1100, 16'h2000, 16'h2100,
        16'h0, 2, 1, 0, 2'd1);
    chk("viol_upd_once", 32'(upd_cnt - u0), 32'd1);

    // Unprotect ignores violation
    run(2'b01, 16'h3000, 16'h3100, 16'h4000, 16'h4100,
        16'h0, 2, 0, 0, 2'd0);
    chk("unprot_en", 32'(last_en), 32'd0);
    violation = 1'b0;

    // Query hit, cmd_valid held while busy
    spm_select_valid = 1'b1;
    d0 = dreq_cnt;
    run(2'b10, 16'h0, 16'h0, 16'h0, 16'h0,
        16'h8010, 6, 0, 3, 2'd0);
    chk("qry_beats", 32'(dreq_cnt - d0), 32'd4);
    chk("qry_d0", 32'(rsp_data0), 32'hA001);
    chk("qry_d1", 32'(rsp_data1), 32'hA002);
    chk("qry_d2", 32'(rsp_data2), 32'hA003);
    chk("qry_d3", 32'(rsp_data3), 32'hA004);

    // Data held across a non-query command
    run(2'b01, 16'h5, 16'h6, 16'h7, 16'h8,
        16'h0, 2, 0, 0, 2'd0);
    chk("held_d0", 32'(rsp_data0), 32'hA001);
    chk("held_d3", 32'(rsp_data3), 32'hA004);

    // Query miss
    spm_select_valid = 1'b0;
    d0 = dreq_cnt;
    run(2'b10, 16'h0, 16'h0, 16'h0, 16'h0,
        16'h8010, 2, 0, 0, 2'd2);
    chk("miss_no_dreq", 32'(dreq_cnt - d0), 32'd0);
    chk("miss_d0", 32'(rsp_data0), 32'h0);

    // Illegal op, stalled response
    u0 = upd_cnt;
    d0 = dreq_cnt;
    run(2'b11, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
        16'hFFFF, 1, 5, 2, 2'd3);
    chk("bad_no_upd", 32'(upd_cnt - u0), 32'd0);
    chk("bad_no_dreq", 32'(dreq_cnt - d0), 32'd0);

    // Second query with different base
    spm_select_valid = 1'b1;
    rd_base = 16'h1230;
    run(2'b10, 16'h0, 16'h0, 16'h0, 16'h0,
        16'h4444, 6, 2, 0, 2'd0);
    chk("qry2_d0", 32'(rsp_data0), 32'h1231);
    chk("qry2_d3", 32'(rsp_data3), 32'h1234);
    rd_base = 16'hA000;

    // Reset during read beat 2
    cmd_op = 2'b10;
    cmd_sel = 16'h8010;
    cmd_valid = 1'b1;
    @(posedge mclk); #1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge mclk);
    #1 chk("beat2_dreq", 32'(data_request), 32'(QFC + 3'd2));
    #1 puc_rst = 1'b1;
    #1;
    chk("rst_dreq", 32'(data_request), 32'd0);
    chk("rst_sel", 32'(spm_select), 32'd0);
    chk("rst_rv", 32'(rsp_valid), 32'd0);
    @(posedge mclk);
    #3 puc_rst = 1'b0;
    #1;
    chk("rel2_ready", 32'(cmd_ready), 32'd1);
    chk("rel2_rv", 32'(rsp_valid), 32'd0);
    chk("rel2_d0", 32'(rsp_data0), 32'd0);
    repeat (8) @(posedge mclk);
    #1 chk("no_late_rsp", 32'(rsp_valid), 32'd0);

    // Recovery
    run(2'b00, 16'h8000, 16'h8100, 16'h9000, 16'h9100,
        16'h0, 2, 0, 0, 2'd0);

    repeat (2) @(posedge mclk);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/omsp_spm_cmd_seq.md
OMSP_SPM_CMD_SEQ -- requirements
Module: omsp_spm_cmd_seq

Interface
REQ-001 SHALL have parameter QRY_FIRST_CODE, default 3'd1: data_request code of the first query word; words use codes QRY_FIRST_CODE..QRY_FIRST_CODE+3.
REQ-002 SHALL have one clock and an asynchronous, active-high reset: mclk  in  1  clock; puc_rst  in  1  reset.
REQ-003 cmd_valid  in  1  command request; cmd_ready  out  1  sequencer idle, accepts command.
REQ-004 cmd_op  in  2  00 protect, 01 unprotect, 10 query, 11 illegal.
REQ-005 cmd_arg0..cmd_arg3  in  16 each  protect layout words (public start/end, secret start/end).
REQ-006 cmd_sel  in  16  address used to select the SPM for a query.
REQ-007 update_spm  out  1  SPM update strobe; enable_spm  out  1  1=create, 0=destroy.
REQ-008 r12, r13, r14, r15  out  16 each  layout words presented to SPM control.
REQ-009 spm_select  out  16  query selector; data_request  out  3  word code, 0 = none.
REQ-010 violation  in  1; spm_select_valid  in  1; requested_data  in  16  (all combinational responses from SPM control).
REQ-011 rsp_valid  out  1; rsp_ready  in  1; rsp_status  out  2  (00 OK, 01 VIOL, 10 NOSPM, 11 BADOP); rsp_data0..rsp_data3  out  16 each.

Function
REQ-012 SHALL implement FSM states IDLE, ISSUE, QSEL, QREAD, RESP.
REQ-013 cmd_ready SHALL be 1 only in IDLE; a command is accepted on a cycle with cmd_valid & cmd_ready, and all cmd_* fields are registered on that edge.
REQ-014 IDLE -> ISSUE on op 00/01; -> QSEL on op 10; -> RESP with status BADOP and zeroed data on op 11.
REQ-015 ISSUE SHALL last exactly one cycle with update_spm=1, enable_spm=1 for protect and 0 for unprotect, and r12..r15 = registered cmd_arg0..3.
REQ-016 For protect, violation SHALL be sampled in the ISSUE cycle; status = VIOL if 1, else OK. Unprotect always yields OK. Next state is RESP.
REQ-017 r12..r15 SHALL be zero outside ISSUE; update_spm SHALL never be high outside ISSUE and never for more than one cycle per command.
REQ-018 QSEL SHALL last one cycle, driving spm_select = registered cmd_sel and data_request = 0; if spm_select_valid = 0, go to RESP with status NOSPM and zeroed data, else go to QREAD.
REQ-019 QREAD SHALL last exactly 4 cycles with beat counter k = 0..3, drive spm_select = cmd_sel and data_request = QRY_FIRST_CODE+k, and capture requested_data into rsp_data[k] on the same edge.
REQ-020 After beat 3, the state SHALL go to RESP with status OK. spm_select_valid SHALL NOT be re-checked during QREAD.
REQ-021 spm_select and data_request SHALL be zero outside QSEL/QREAD.
REQ-022 RESP SHALL assert rsp_valid with stable status and data until rsp_valid & rsp_ready; it then returns to IDLE on the next edge.
REQ-023 rsp_valid SHALL NOT depend combinationally on rsp_ready.
REQ-024 Latency from accept edge to first rsp_valid SHALL be: protect/unprotect 2 cycles, query hit 6, query miss 2, BADOP 1.
REQ-025 Back-to-back commands are allowed: cmd_ready rises the cycle after the response handshake.
REQ-026 cmd_valid while busy SHALL be ignored and not queued.
REQ-027 rsp_data SHALL hold its last value after the handshake until overwritten by the next query, miss, or BADOP.

Reset
REQ-028 puc_rst SHALL asynchronously force IDLE, k=0, and all registered fields to 0.
REQ-029 During reset all outputs SHALL be 0 except cmd_ready, which is 1 once puc_rst deasserts.
REQ-030 Reset mid-ISSUE or mid-QREAD SHALL drop update_spm and data_request immediately and SHALL produce no response.

Verification
REQ-031 Protect args 0x8000/0x8100/0x9000/0x9100, violation=0 -> single-cycle update_spm=1, enable_spm=1 with r12=0x8000 and r15=0x9100; rsp_status=00 two cycles after accept.
REQ-032 Protect with violation=1 in the ISSUE cycle -> rsp_status=01; update_spm high for exactly one cycle.
REQ-033 Query cmd_sel=0x8010, spm_select_valid=1, requested_data = 0xA000+code -> data_request 1,2,3,4 in successive cycles; rsp_data0..3 = 0xA001..0xA004 with status 00.
REQ-034 Query with spm_select_valid=0 -> data_request never nonzero; rsp_status=10 and data=0.
REQ-035 cmd_op=11 -> no update_spm or data_request; rsp_status=11 one cycle after accept. rsp_ready held 0 for 5 cycles -> rsp_valid and fields stable throughout.
REQ-036 puc_rst asserted during QREAD beat 2 -> data_request=0 immediately; after release cmd_ready=1 and rsp_valid=0.
